// File: rtl/priv_trap_sequencer_pkg.sv
// Shared types and constants for the machine-mode trap/return sequencer.
// Holds the 32-bit word type, the trap kind and FSM state enums, the
// synchronous-exception and interrupt mcause codes, and a helper that
// tells whether a synchronous exception cause reports badaddr in mtval.
package machine_mode_types_1_11_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    EXC = 2'd0,
    INT = 2'd1,
    RET = 2'd2
  } trap_kind_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEAR    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  // Synchronous exception cause codes
  localparam logic [30:0] CAUSE_MAL_INSN     = 31'd0;
  localparam logic [30:0] CAUSE_FAULT_INSN   = 31'd1;
  localparam logic [30:0] CAUSE_ILLEGAL_INSN = 31'd2;
  localparam logic [30:0] CAUSE_BREAKPOINT   = 31'd3;
  localparam logic [30:0] CAUSE_MAL_L        = 31'd4;
  localparam logic [30:0] CAUSE_FAULT_L      = 31'd5;
  localparam logic [30:0] CAUSE_MAL_S        = 31'd6;
  localparam logic [30:0] CAUSE_FAULT_S      = 31'd7;
  localparam logic [30:0] CAUSE_ENV_M        = 31'd11;

  // Interrupt cause codes
  localparam logic [30:0] CAUSE_IRQ_SW  = 31'd3;
  localparam logic [30:0] CAUSE_IRQ_TMR = 31'd7;
  localparam logic [30:0] CAUSE_IRQ_EXT = 31'd11;

  // Address-related exceptions carry badaddr into mtval; everything else writes 0.
  function automatic logic cause_has_tval(input logic [30:0] cause);
    logic sel;
    case (cause)
      31'd0, 31'd1, 31'd4, 31'd5, 31'd6, 31'd7: sel = 1'b1;
      default:                                  sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/priv_trap_sequencer_priority_enc.sv
// trap_priority_enc: combinational priority encoder for trap/return events.
// Ports:
//   exception flags, ex_rmgmt/ex_rmgmt_cause, ret, irq_* : event sources
//   valid    : some event is present
//   kind     : EXC / RET / INT (exceptions beat ret, ret beats interrupts)
//   cause    : 31-bit mcause code for the winning event
//   tval_sel : mtval should take badaddr (address-related exceptions only)
module trap_priority_enc
  import machine_mode_types_1_11_pkg::*;
#(
  parameter int NUM_EXTENSIONS   = 2,
  parameter int RMGMT_CAUSE_BASE = 24,
  localparam int CW = (NUM_EXTENSIONS > 1) ? $clog2(NUM_EXTENSIONS) : 1
) (
  input  logic          fault_insn,
  input  logic          mal_insn,
  input  logic          illegal_insn,
  input  logic          breakpoint,
  input  logic          env_m,
  input  logic          mal_l,
  input  logic          mal_s,
  input  logic          fault_l,
  input  logic          fault_s,
  input  logic          ex_rmgmt,
  input  logic [CW-1:0] ex_rmgmt_cause,
  input  logic          ret,
  input  logic          irq_ext,
  input  logic          irq_sw,
  input  logic          irq_tmr,
  output logic          valid,
  output trap_kind_t    kind,
  output logic [30:0]   cause,
  output logic          tval_sel
);

  localparam logic [30:0] RMGMT_BASE = 31'(RMGMT_CAUSE_BASE);

  logic [30:0] rmgmt_cause_s;
  assign rmgmt_cause_s = RMGMT_BASE + {{(31-CW){1'b0}}, ex_rmgmt_cause};

  // Fixed-priority selection of the single event to take
  always_comb begin
    valid    = 1'b1;
    kind     = EXC;
    cause    = 31'd0;
    tval_sel = 1'b0;
    if (fault_insn)        cause = CAUSE_FAULT_INSN;
    else if (mal_insn)     cause = CAUSE_MAL_INSN;
    else if (illegal_insn) cause = CAUSE_ILLEGAL_INSN;
    else if (breakpoint)   cause = CAUSE_BREAKPOINT;
    else if (env_m)        cause = CAUSE_ENV_M;
    else if (mal_l)        cause = CAUSE_MAL_L;
    else if (mal_s)        cause = CAUSE_MAL_S;
    else if (fault_l)      cause = CAUSE_FAULT_L;
    else if (fault_s)      cause = CAUSE_FAULT_S;
    else if (ex_rmgmt)     cause = rmgmt_cause_s;
    else if (ret)          kind  = RET;
    else if (irq_ext) begin
      kind  = INT;
      cause = CAUSE_IRQ_EXT;
    end else if (irq_sw) begin
      kind  = INT;
      cause = CAUSE_IRQ_SW;
    end else if (irq_tmr) begin
      kind  = INT;
      cause = CAUSE_IRQ_TMR;
    end else begin
      valid = 1'b0;
    end
    if (valid && (kind == EXC)) tval_sel = cause_has_tval(cause);
    else                        tval_sel = 1'b0;
  end

endmodule

// File: rtl/priv_trap_sequencer.sv
// priv_trap_sequencer: takes one trap/return event at a time in IDLE, waits
// for the pipeline to drain (CLEAR), strobes the CSR updates (COMMIT) and then
// redirects fetch (REDIRECT).
// Ports:
//   CLK, RST                       : clock, synchronous active-high reset
//   exception flags, ret, irq_*    : event sources, sampled only in IDLE
//   pipe_clear                     : pipeline drained, consulted only in CLEAR
//   epc, badaddr                   : faulting PC and trap value, latched with the event
//   mtvec, mepc                    : current CSR values used for the redirect target
//   insert_pc, priv_pc, intr       : redirect strobe/target and interrupt flag
//   *_we, *_wdata, mstatus_push/pop: CSR update strobes and data
//   busy                           : FSM not in IDLE
// All outputs are decoded from registered state; none depend on inputs
// combinationally.
module priv_trap_sequencer
  import machine_mode_types_1_11_pkg::*;
#(
  parameter int NUM_EXTENSIONS   = 2,
  parameter int RMGMT_CAUSE_BASE = 24,
  localparam int CW = (NUM_EXTENSIONS > 1) ? $clog2(NUM_EXTENSIONS) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          fault_insn,
  input  logic          mal_insn,
  input  logic          illegal_insn,
  input  logic          breakpoint,
  input  logic          env_m,
  input  logic          mal_l,
  input  logic          mal_s,
  input  logic          fault_l,
  input  logic          fault_s,
  input  logic          ex_rmgmt,
  input  logic [CW-1:0] ex_rmgmt_cause,
  input  logic          ret,
  input  logic          pipe_clear,
  input  word_t         epc,
  input  word_t         badaddr,
  input  logic          irq_ext,
  input  logic          irq_sw,
  input  logic          irq_tmr,
  input  word_t         mtvec,
  input  word_t         mepc,
  output logic          insert_pc,
  output word_t         priv_pc,
  output logic          intr,
  output logic          mepc_we,
  output logic          mcause_we,
  output logic          mtval_we,
  output word_t         mepc_wdata,
  output word_t         mcause_wdata,
  output word_t         mtval_wdata,
  output logic          mstatus_push,
  output logic          mstatus_pop,
  output logic          busy
);

  state_t      state_r, state_next_s;
  trap_kind_t  kind_r;
  logic [30:0] cause_r;
  word_t       epc_r, tval_r, priv_pc_r, target_s, base_s;

  logic        enc_valid_s, enc_tval_sel_s;
  trap_kind_t  enc_kind_s;
  logic [30:0] enc_cause_s;

  trap_priority_enc #(
    .NUM_EXTENSIONS   (NUM_EXTENSIONS),
    .RMGMT_CAUSE_BASE (RMGMT_CAUSE_BASE)
  ) u_enc (
    .fault_insn     (fault_insn),
    .mal_insn       (mal_insn),
    .illegal_insn   (illegal_insn),
    .breakpoint     (breakpoint),
    .env_m          (env_m),
    .mal_l          (mal_l),
    .mal_s          (mal_s),
    .fault_l        (fault_l),
    .fault_s        (fault_s),
    .ex_rmgmt       (ex_rmgmt),
    .ex_rmgmt_cause (ex_rmgmt_cause),
    .ret            (ret),
    .irq_ext        (irq_ext),
    .irq_sw         (irq_sw),
    .irq_tmr        (irq_tmr),
    .valid          (enc_valid_s),
    .kind           (enc_kind_s),
    .cause          (enc_cause_s),
    .tval_sel       (enc_tval_sel_s)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:     if (enc_valid_s) state_next_s = CLEAR;  else state_next_s = IDLE;
      CLEAR:    if (pipe_clear)  state_next_s = COMMIT; else state_next_s = CLEAR;
      COMMIT:   state_next_s = REDIRECT;
      REDIRECT: state_next_s = IDLE;
      default:  state_next_s = IDLE;
    endcase
  end

  // Capture the winning event only when it is accepted in IDLE
  always_ff @(posedge CLK) begin
    if (RST) begin
      kind_r  <= EXC;
      cause_r <= 31'd0;
      epc_r   <= 32'd0;
      tval_r  <= 32'd0;
    end else if ((state_r == IDLE) && enc_valid_s) begin
      kind_r  <= enc_kind_s;
      cause_r <= enc_cause_s;
      epc_r   <= epc;
      tval_r  <= enc_tval_sel_s ? badaddr : 32'd0;
    end else begin
      kind_r  <= kind_r;
      cause_r <= cause_r;
      epc_r   <= epc_r;
      tval_r  <= tval_r;
    end
  end

  // Redirect target; reserved mtvec modes fall through to direct
  always_comb begin
    base_s = mtvec & 32'hFFFF_FFFC;
    if (kind_r == RET)                              target_s = mepc;
    else if ((kind_r == INT) && (mtvec[1:0] == 2'b01)) target_s = base_s + {cause_r[29:0], 2'b00};
    else                                            target_s = base_s;
  end

  // Target sampled at the COMMIT->REDIRECT edge so priv_pc carries no input path
  always_ff @(posedge CLK) begin
    if (RST)                    priv_pc_r <= 32'd0;
    else if (state_r == COMMIT) priv_pc_r <= target_s;
    else                        priv_pc_r <= 32'd0;
  end

  // FSM output decode
  always_comb begin
    insert_pc    = 1'b0;
    priv_pc      = 32'd0;
    intr         = 1'b0;
    mepc_we      = 1'b0;
    mcause_we    = 1'b0;
    mtval_we     = 1'b0;
    mepc_wdata   = 32'd0;
    mcause_wdata = 32'd0;
    mtval_wdata  = 32'd0;
    mstatus_push = 1'b0;
    mstatus_pop  = 1'b0;
    busy         = (state_r != IDLE);
    case (state_r)
      IDLE: begin
        intr = 1'b0;
      end
      CLEAR: begin
        intr = (kind_r == INT);
      end
      COMMIT: begin
        intr = (kind_r == INT);
        if (kind_r == RET) begin
          mstatus_pop = 1'b1;
        end else begin
          mepc_we      = 1'b1;
          mcause_we    = 1'b1;
          mtval_we     = 1'b1;
          mstatus_push = 1'b1;
          mepc_wdata   = epc_r & 32'hFFFF_FFFC;
          mcause_wdata = {(kind_r == INT), cause_r};
          mtval_wdata  = tval_r;
        end
      end
      REDIRECT: begin
        intr      = (kind_r == INT);
        insert_pc = 1'b1;
        priv_pc   = priv_pc_r;
      end
      default: begin
        intr = 1'b0;
      end
    endcase
  end

endmodule
